lpddr_burst_reader_16bit: RTL

Frame/line read DMA that sits beside the 16-bit LPDDR burst write driver on the same LPDDR controller Avalon-MM slave port.
- Fetches a contiguous region from LPDDR in fixed 64-word bursts.
- Buffers returned 32-bit words in an internal FIFO.
- Unpacks each word into two 16-bit pixels and presents them as a valid/ready stream to the video correction pipeline.
- Single clock domain: avmm_m_clk.

---
 rtl/lpddr_burst_reader_16bit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/lpddr_burst_reader_16bit.sv
// Burst read DMA: fetches LPDDR bursts into a word FIFO and unpacks them into a 16-bit pixel stream.
// Optional macro BURST_READER_HIGH_FIRST_EN emits readdata[31:16] before readdata[15:0].
module lpddr_burst_reader_16bit #(
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned LEN_W      = 24
) (
    input  logic             avmm_m_clk,
    input  logic             avmm_m_rst,
    input  logic             start,
    input  logic [29:0]      base_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [31:0]      avmm_m_address,
    output logic [6:0]       avmm_m_burstcount,
    output logic             avmm_m_read,
    input  logic             avmm_m_waitrequest,
    input  logic [31:0]      avmm_m_readdata,
    input  logic             avmm_m_readdatavalid,
    output logic [15:0]      pix_data,
    output logic             pix_valid,
    input  logic             pix_ready
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned BL_SH = $clog2(BURST_LEN);

    typedef enum logic [1:0] {IDLE, CHECK, REQ, DRAIN} state_t;

    state_t           state;
    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    fifo_cnt, outstanding;
    logic [29:0]      word_addr;
    logic [LEN_W-1:0] bursts_left;
    logic [15:0]      hold_half;
    logic             hold_valid;

    logic        fifo_full, fifo_empty, push, pop, slot_free, issue, ret_dec;
    logic        credit_ok, last_handshake, all_empty;
    logic [31:0] fifo_word;
    logic [15:0] first_half, second_half;

    assign avmm_m_burstcount = 7'(BURST_LEN);

    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = avmm_m_readdatavalid && !fifo_full;
    assign slot_free  = !pix_valid || pix_ready;
    assign pop        = slot_free && !hold_valid && !fifo_empty;
    assign fifo_word  = mem[rd_ptr];
    assign issue      = avmm_m_read && !avmm_m_waitrequest;
    assign ret_dec    = avmm_m_readdatavalid && (outstanding != '0);
    assign credit_ok  = ({2'b00, fifo_cnt} + {2'b00, outstanding} + (CW+2)'(BURST_LEN))
                        <= (CW+2)'(FIFO_DEPTH);

    // done is raised on the edge of the final pixel handshake so it appears the cycle after it
    assign last_handshake = pix_valid && pix_ready && !hold_valid && fifo_empty && (outstanding == '0);
    assign all_empty      = !pix_valid && !hold_valid && fifo_empty && (outstanding == '0);

`ifdef BURST_READER_HIGH_FIRST_EN
    assign first_half  = fifo_word[31:16];
    assign second_half = fifo_word[15:0];
`else
    assign first_half  = fifo_word[15:0];
    assign second_half = fifo_word[31:16];
`endif

    always_ff @(posedge avmm_m_clk or posedge avmm_m_rst) begin
        if (avmm_m_rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            overflow       <= 1'b0;
            avmm_m_read    <= 1'b0;
            avmm_m_address <= '0;
            outstanding    <= '0;
            word_addr      <= '0;
            bursts_left    <= '0;
        end else begin
            done <= 1'b0;
            if (avmm_m_readdatavalid && fifo_full)
                overflow <= 1'b1;
            outstanding <= outstanding + (issue ? CW'(BURST_LEN) : '0) - (ret_dec ? CW'(1) : '0);
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_words != '0) begin
                            word_addr   <= base_addr;
                            bursts_left <= len_words >> BL_SH;
                            busy        <= 1'b1;
                            state       <= CHECK;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (credit_ok) begin
                        avmm_m_read    <= 1'b1;
                        avmm_m_address <= {word_addr, 2'b00};
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (!avmm_m_waitrequest) begin
                        avmm_m_read <= 1'b0;
                        word_addr   <= word_addr + 30'(BURST_LEN);
                        bursts_left <= bursts_left - LEN_W'(1);
                        state       <= (bursts_left == LEN_W'(1)) ? DRAIN : CHECK;
                    end
                end
                DRAIN: begin
                    if (last_handshake || all_empty) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge avmm_m_clk) begin
        if (push)
            mem[wr_ptr] <= avmm_m_readdata;
    end

    always_ff @(posedge avmm_m_clk or posedge avmm_m_rst) begin
        if (avmm_m_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Output slot refills on the same edge it empties, giving one pixel per clock
    always_ff @(posedge avmm_m_clk or posedge avmm_m_rst) begin
        if (avmm_m_rst) begin
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            hold_half  <= '0;
            hold_valid <= 1'b0;
        end else if (slot_free) begin
            if (hold_valid) begin
                pix_data   <= hold_half;
                pix_valid  <= 1'b1;
                hold_valid <= 1'b0;
            end else if (!fifo_empty) begin
                pix_data   <= first_half;
                hold_half  <= second_half;
                hold_valid <= 1'b1;
                pix_valid  <= 1'b1;
            end else begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule
